// File: rtl/branch_ctrl.sv
// Program counter and conditional-branch resolver for the 8-bit MCU.
// Branches issued while the flags register is loading are held until the flags settle.
module branch_ctrl #(
  parameter int unsigned               PC_WIDTH     = 8,
  parameter logic        [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_en,
  input  logic                br_req,
  input  logic [2:0]          br_cond,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                flags_pending,
  input  logic                zero,
  input  logic                carry,
  input  logic                overflow,
  output logic [PC_WIDTH-1:0] pc,
  output logic                br_busy,
  output logic                br_done,
  output logic                br_taken,
  output logic                flush
);

  typedef enum logic [0:0] {StIdle, StWaitFlags} state_e;

  localparam logic [PC_WIDTH-1:0] PcOne = PC_WIDTH'(1);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [2:0]            cond_q, cond_d;
  logic [PC_WIDTH-1:0]   target_q, target_d;
  logic                  done_q, done_d;
  logic                  taken_q, taken_d;

  logic                  resolve;
  logic [2:0]            eval_cond;
  logic [PC_WIDTH-1:0]   eval_target;
  logic                  cond_met;

  always_comb begin
    unique case (eval_cond)
      3'b000:  cond_met = 1'b1;
      3'b001:  cond_met = zero;
      3'b010:  cond_met = ~zero;
      3'b011:  cond_met = carry;
      3'b100:  cond_met = ~carry;
      3'b101:  cond_met = overflow;
      3'b110:  cond_met = ~overflow;
      default: cond_met = 1'b0;  // reserved code: never taken
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cond_d      = cond_q;
    target_d    = target_q;
    done_d      = 1'b0;
    taken_d     = 1'b0;
    resolve     = 1'b0;
    eval_cond   = br_cond;
    eval_target = br_target;

    unique case (state_q)
      StIdle: begin
        if (br_req) begin
          if (flags_pending) begin
            cond_d   = br_cond;
            target_d = br_target;
            state_d  = StWaitFlags;
          end else begin
            resolve = 1'b1;
          end
        end else if (pc_en) begin
          pc_d = pc_q + PcOne;
        end
      end
      StWaitFlags: begin
        eval_cond   = cond_q;
        eval_target = target_q;
        if (!flags_pending) begin
          resolve = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (resolve) begin
      done_d  = 1'b1;
      taken_d = cond_met;
      pc_d    = cond_met ? eval_target : pc_q + PcOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_VECTOR;
      cond_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cond_q   <= cond_d;
      target_q <= target_d;
      done_q   <= done_d;
      taken_q  <= taken_d;
    end
  end

  assign pc       = pc_q;
  assign br_busy  = (state_q == StWaitFlags);
  assign br_done  = done_q;
  assign br_taken = taken_q;
  assign flush    = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed and random checks of branch_ctrl against a transaction-level reference model.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_en, br_req, flags_pending, zero, carry, overflow;
  logic [2:0] br_cond;
  logic [7:0] br_target;
  logic [7:0] pc;
  logic       br_busy, br_done, br_taken, flush;

  int checks = 0;
  int fails  = 0;

  // Reference model state: pending branch (if any) and the architectural PC.
  int         m_pc;
  bit         m_busy;
  logic [2:0] m_cond;
  logic [7:0] m_target;
  bit         e_done, e_taken;

  branch_ctrl #(.PC_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_en         (pc_en),
    .br_req        (br_req),
    .br_cond       (br_cond),
    .br_target     (br_target),
    .flags_pending (flags_pending),
    .zero          (zero),
    .carry         (carry),
    .overflow      (overflow),
    .pc            (pc),
    .br_busy       (br_busy),
    .br_done       (br_done),
    .br_taken      (br_taken),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] cond);
    logic [7:0] tbl;
    tbl = {1'b0, ~overflow, overflow, ~carry, carry, ~zero, zero, 1'b1};
    return tbl[cond];
  endfunction

  task automatic model_resolve(input logic [2:0] cond, input logic [7:0] target);
    e_taken = ref_taken(cond);
    e_done  = 1'b1;
    m_pc    = e_taken ? int'(target) : (m_pc + 1) % 256;
  endtask

  task automatic model_reset();
    m_pc = 0; m_busy = 0; e_done = 0; e_taken = 0;
  endtask

  // Predict the effect of the current inputs, clock once, then compare all outputs.
  task automatic step();
    e_done  = 0;
    e_taken = 0;
    if (!m_busy) begin
      if (br_req) begin
        if (flags_pending) begin
          m_busy = 1; m_cond = br_cond; m_target = br_target;
        end else begin
          model_resolve(br_cond, br_target);
        end
      end else if (pc_en) begin
        m_pc = (m_pc + 1) % 256;
      end
    end else if (!flags_pending) begin
      m_busy = 0;
      model_resolve(m_cond, m_target);
    end
    @(posedge clk);
    #1;
    check("pc", pc, m_pc[7:0]);
    check("br_busy", br_busy, m_busy);
    check("br_done", br_done, e_done);
    check("br_taken", br_taken, e_taken);
    check("flush", flush, e_taken);
  endtask

  task automatic idle_inputs();
    pc_en = 0; br_req = 0; flags_pending = 0; br_cond = 3'b000; br_target = 8'h00;
  endtask

  task automatic set_pc(input logic [7:0] t);
    br_req = 1; br_cond = 3'b000; br_target = t; flags_pending = 0; pc_en = 0;
    step();
    idle_inputs();
  endtask

  initial begin
    reset = 1; zero = 0; carry = 0; overflow = 0;
    idle_inputs();
    model_reset();
    #2;
    check("rst_pc", pc, 8'h00);
    check("rst_busy", br_busy, 1'b0);
    check("rst_done", br_done, 1'b0);
    check("rst_flush", flush, 1'b0);
    #10 reset = 0;

    // Sequential wrap
    set_pc(8'hFE);
    pc_en = 1;
    step(); check("wrap0", pc, 8'hFF);
    step(); check("wrap1", pc, 8'h00);
    step(); check("wrap2", pc, 8'h01);
    idle_inputs();

    // Unconditional taken
    set_pc(8'h10);
    br_req = 1; br_cond = 3'b000; br_target = 8'h80;
    step();
    check("uncond_pc", pc, 8'h80);
    check("uncond_taken", br_taken, 1'b1);
    idle_inputs();
    step();
    check("uncond_pulse_end", br_done, 1'b0);

    // Not taken, br_req has priority over pc_en; then reserved code
    set_pc(8'h20);
    zero = 0; br_req = 1; br_cond = 3'b001; br_target = 8'h40; pc_en = 1;
    step();
    check("nt_pc", pc, 8'h21);
    check("nt_flush", flush, 1'b0);
    idle_inputs();
    set_pc(8'h20);
    zero = 1; br_req = 1; br_cond = 3'b111; br_target = 8'h40; pc_en = 1;
    step();
    check("rsv_pc", pc, 8'h21);
    check("rsv_done", br_done, 1'b1);
    idle_inputs();

    // Interlock: flags load turns Z on while the branch waits
    set_pc(8'h30);
    zero = 0; flags_pending = 1; br_req = 1; br_cond = 3'b001; br_target = 8'h55;
    step();
    check("il_busy", br_busy, 1'b1);
    check("il_hold", pc, 8'h30);
    idle_inputs();
    zero = 1;
    step();
    check("il_pc", pc, 8'h55);
    check("il_taken", br_taken, 1'b1);

    // Extended interlock with pc_en pulses while busy
    set_pc(8'h60);
    carry = 0; flags_pending = 1; br_req = 1; br_cond = 3'b100; br_target = 8'h99;
    step();
    br_req = 0; pc_en = 1;
    step();
    pc_en = 0; carry = 1;
    step();
    check("ext_busy3", br_busy, 1'b1);
    check("ext_hold", pc, 8'h60);
    flags_pending = 0; pc_en = 1;
    step();
    check("ext_pc", pc, 8'h61);
    check("ext_taken", br_taken, 1'b0);
    idle_inputs();

    // Reset mid-run while a branch waits
    set_pc(8'h37);
    flags_pending = 1; br_req = 1; br_cond = 3'b000; br_target = 8'hAA;
    step();
    check("pre_rst_busy", br_busy, 1'b1);
    idle_inputs();
    #2 reset = 1;
    #1;
    model_reset();
    check("async_rst_pc", pc, 8'h00);
    check("async_rst_busy", br_busy, 1'b0);
    #3 reset = 0;
    step();
    check("post_rst_done", br_done, 1'b0);
    pc_en = 1;
    step();
    check("post_rst_pc", pc, 8'h01);
    idle_inputs();

    // Random traffic, obeying the no-request-while-busy contract
    for (int i = 0; i < 400; i++) begin
      zero          = 1'($urandom);
      carry         = 1'($urandom);
      overflow      = 1'($urandom);
      pc_en         = 1'($urandom);
      flags_pending = ($urandom_range(0, 9) < 4);
      br_req        = !m_busy && ($urandom_range(0, 9) < 4);
      br_cond       = 3'($urandom);
      br_target     = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
